ledpanel_bridge: RTL and testbench

Memory-mapped slave between the PicoRV32 memory bus and the LED panel driver's pixel write port. It buffers CPU pixel writes in a FIFO and drains them into the panel driver under its ready backpressure. It also adds a hardware rectangle-fill engine and a readable status register, so firmware need not poll or issue one store per pixel.

---
 rtl/ledpanel_pkg.sv | 30 +++
 rtl/ledpanel_fifo.sv | 67 ++++++
 rtl/ledpanel_bridge.sv | 175 +++++++++++++++++
 tb/tb_ledpanel_bridge.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledpanel_pkg.sv
// Shared types and constants for the LED panel bridge and its pixel FIFO.
package ledpanel_pkg;

  localparam int COORD_W = 5;
  localparam int RGB_W   = 24;

  localparam logic [12:0] OFS_STATUS = 13'h1000;
  localparam logic [12:0] OFS_RECT   = 13'h1004;
  localparam logic [12:0] OFS_COLOR  = 13'h1008;

  typedef struct packed {
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] x;
    logic [RGB_W-1:0]   rgb;
  } pixel_t;

  // x0 sits in the low bits, matching the RECT register layout.
  typedef struct packed {
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] x0;
  } rect_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_e;

endpackage

// File: rtl/ledpanel_fifo.sv
// Synchronous pixel FIFO with occupancy level; one push and one pop per cycle.
module ledpanel_fifo
  import ledpanel_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  pixel_t                   push_data,
  input  logic                     pop,
  output pixel_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

  pixel_t          mem_q [DEPTH];
  pixel_t          mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  assign full     = (count_q == DEPTH_L);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Next storage/pointer/count values; callers guarantee no push when full, no pop when empty.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ledpanel_bridge.sv
// PicoRV32 bus slave feeding the LED panel pixel port through a FIFO,
// with a rectangle-fill engine and a STATUS register.
//
// Fill FSM states:
//   state     | meaning
//   FILL_IDLE | no fill in progress; CPU pixel/RECT/COLOR writes accepted
//   FILL_RUN  | pushing (cx,cy,colour) row-major whenever the FIFO has room
module ledpanel_bridge
  import ledpanel_pkg::*;
#(
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [3:0] BASE_NIBBLE = 4'h1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                mem_valid,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic                mem_ready,
  output logic [31:0]         mem_rdata,
  input  logic                led_wr_ready,
  output logic                led_wr_enable,
  output logic [COORD_W-1:0]  led_wr_addr_x,
  output logic [COORD_W-1:0]  led_wr_addr_y,
  output logic [RGB_W-1:0]    led_wr_rgb_data
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  fill_state_e         state_q, state_d;
  rect_t               rect_q, rect_d;
  logic [RGB_W-1:0]    color_q, color_d;
  logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
  logic                mem_ready_q, mem_ready_d;
  logic [31:0]         mem_rdata_q, mem_rdata_d;
  logic                led_en_q, led_en_d;
  pixel_t              led_pix_q, led_pix_d;

  logic [12:0]  offset;
  logic         is_wr, is_pix, is_rect, is_color, is_status;
  logic         hit, stall, accept, fill_busy;
  logic         pix_wr, color_wr, fill_push;
  logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
  pixel_t       fifo_wdata, fifo_rdata;
  logic [LW-1:0] fifo_level;
  logic [31:0]  status_word;
  logic         unused_bits;

  assign unused_bits = ^{mem_addr[27:13], mem_wdata[31:24]};

  assign fill_busy   = (state_q == FILL_RUN);
  assign status_word = {22'd0, fifo_full, fill_busy, 8'(fifo_level)};

  // Address decode, stall rules and registered bus acknowledge.
  always_comb begin
    offset      = mem_addr[12:0];
    is_wr       = |mem_wstrb;
    is_pix      = ~offset[12];
    is_rect     = (offset == OFS_RECT);
    is_color    = (offset == OFS_COLOR);
    is_status   = (offset == OFS_STATUS);
    hit         = mem_valid && (mem_addr[31:28] == BASE_NIBBLE) && !mem_ready_q;
    stall       = is_wr && ((is_pix && (fifo_full || fill_busy)) ||
                            ((is_rect || is_color) && fill_busy));
    accept      = hit && !stall;
    pix_wr      = accept && is_wr && is_pix;
    color_wr    = accept && is_wr && is_color;
    rect_d      = rect_q;
    color_d     = color_q;
    mem_ready_d = accept;
    mem_rdata_d = '0;
    if (accept && is_wr && is_rect) begin
      rect_d = rect_t'(mem_wdata[19:0]);
    end
    if (color_wr) begin
      color_d = mem_wdata[RGB_W-1:0];
    end
    if (accept && !is_wr && is_status) begin
      mem_rdata_d = status_word;
    end
  end

  // Fill engine next state: walks the rectangle row-major, one pixel per non-full cycle.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    fill_push = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (color_wr) begin
          cx_d = rect_q.x0;
          cy_d = rect_q.y0;
          if ((rect_q.x1 >= rect_q.x0) && (rect_q.y1 >= rect_q.y0)) begin
            state_d = FILL_RUN;
          end
        end
      end
      FILL_RUN: begin
        if (!fifo_full) begin
          fill_push = 1'b1;
          if ((cx_q == rect_q.x1) && (cy_q == rect_q.y1)) begin
            state_d = FILL_IDLE;
          end else if (cx_q == rect_q.x1) begin
            cx_d = rect_q.x0;
            cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  // FIFO push mux (fill and CPU pushes are mutually exclusive) and drain to the panel.
  always_comb begin
    fifo_push  = fill_push || pix_wr;
    fifo_wdata = fill_push ? pixel_t'{y: cy_q, x: cx_q, rgb: color_q}
                           : pixel_t'{y: mem_addr[11:7], x: mem_addr[6:2],
                                      rgb: mem_wdata[RGB_W-1:0]};
    fifo_pop   = !fifo_empty && led_wr_ready;
    led_en_d   = fifo_pop;
    led_pix_d  = led_pix_q;
    if (fifo_pop) begin
      led_pix_d = fifo_rdata;
    end
  end

  // All bridge state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= FILL_IDLE;
      rect_q      <= '0;
      color_q     <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      led_en_q    <= 1'b0;
      led_pix_q   <= '0;
    end else begin
      state_q     <= state_d;
      rect_q      <= rect_d;
      color_q     <= color_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      led_en_q    <= led_en_d;
      led_pix_q   <= led_pix_d;
    end
  end

  ledpanel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign mem_ready       = mem_ready_q;
  assign mem_rdata       = mem_rdata_q;
  assign led_wr_enable   = led_en_q;
  assign led_wr_addr_x   = led_pix_q.x;
  assign led_wr_addr_y   = led_pix_q.y;
  assign led_wr_rgb_data = led_pix_q.rgb;

endmodule

// File: tb/tb_ledpanel_bridge.sv
// Bench for ledpanel_bridge: bus master tasks, strobe monitor and a
// queue-based reference of the expected pixel stream.
module tb_ledpanel_bridge;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        led_wr_ready = 1'b0;
  logic        led_wr_enable;
  logic [4:0]  led_wr_addr_x, led_wr_addr_y;
  logic [23:0] led_wr_rgb_data;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ready_mode = 0;   // 0 = hold low, 1 = hold high, 2 = random
  logic [33:0] obs_q[$];
  logic [33:0] exp_q[$];

  ledpanel_bridge #(.FIFO_DEPTH(8), .BASE_NIBBLE(4'h1)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .mem_valid       (mem_valid),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_ready       (mem_ready),
    .mem_rdata       (mem_rdata),
    .led_wr_ready    (led_wr_ready),
    .led_wr_enable   (led_wr_enable),
    .led_wr_addr_x   (led_wr_addr_x),
    .led_wr_addr_y   (led_wr_addr_y),
    .led_wr_rgb_data (led_wr_rgb_data)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: led_wr_ready = 1'b0;
        1: led_wr_ready = 1'b1;
        default: led_wr_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  always @(negedge clk) begin
    if (resetn && led_wr_enable)
      obs_q.push_back({led_wr_addr_y, led_wr_addr_x, led_wr_rgb_data});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the handshake (or budget expiry).
  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input int budget, input bit allow_timeout,
                            output logic [31:0] rdata, output bit acked);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    acked = 1'b0; rdata = '0;
    for (int i = 0; i < budget && !acked; i++) begin
      @(negedge clk);
      if (mem_ready) begin acked = 1'b1; rdata = mem_rdata; end
    end
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = '0;
    if (!acked && !allow_timeout) begin
      total_cnt++;
      $display("FAIL bus_timeout addr=%h: mem_ready not seen within %0d cycles", addr, budget);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r; bit a;
    bus_access(addr, data, 4'hF, 300, 1'b0, r, a);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    bit a;
    bus_access(addr, 32'h0, 4'h0, 300, 1'b0, data, a);
  endtask

  function automatic logic [31:0] pix_addr(input logic [4:0] x, input logic [4:0] y);
    return {20'h10000, y, x, 2'b00};
  endfunction

  function automatic logic [31:0] rect_word(input int x0, input int y0, input int x1, input int y1);
    return {12'd0, 5'(y1), 5'(x1), 5'(y0), 5'(x0)};
  endfunction

  // Reference: every pixel of the rectangle in row-major order, nothing if empty.
  function automatic void model_fill(input int x0, input int y0, input int x1, input int y1,
                                     input logic [23:0] rgb);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        exp_q.push_back({5'(yy), 5'(xx), rgb});
  endfunction

  function automatic int first_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  task automatic wait_drain(input int n);
    for (int i = 0; i < 400 && obs_q.size() < n; i++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic clear_queues();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    resetn = 1'b0; ready_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) $display("FAIL reset_bus: ready=%b rdata=%h want 0/0", mem_ready, mem_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({led_wr_enable, led_wr_addr_x, led_wr_addr_y, led_wr_rgb_data} !== 35'h0)
      $display("FAIL reset_led: en=%b x=%0d y=%0d rgb=%h want all 0", led_wr_enable, led_wr_addr_x, led_wr_addr_y, led_wr_rgb_data);
    else pass_cnt++;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    rd(32'h1000_1000, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL reset_status: got %h want %h", r, 32'h0); else pass_cnt++;
  endtask

  task automatic test_single();
    ready_mode = 1;
    repeat (3) @(posedge clk); #1;
    clear_queues();
    mem_valid = 1'b1; mem_addr = 32'h1000_0084; mem_wdata = 32'h00FF_0000; mem_wstrb = 4'hF;
    @(negedge clk);
    total_cnt++;
    if (mem_ready !== 1'b0) $display("FAIL single_ready_early: got %b want 0", mem_ready); else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (mem_ready !== 1'b1 || led_wr_enable !== 1'b0)
      $display("FAIL single_ack: ready=%b en=%b want 1/0", mem_ready, led_wr_enable);
    else pass_cnt++;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    total_cnt++;
    if (led_wr_enable !== 1'b1 || led_wr_addr_x !== 5'd1 || led_wr_addr_y !== 5'd1 || led_wr_rgb_data !== 24'hFF0000)
      $display("FAIL single_strobe: en=%b x=%0d y=%0d rgb=%h want 1/1/1/ff0000", led_wr_enable, led_wr_addr_x, led_wr_addr_y, led_wr_rgb_data);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (led_wr_enable !== 1'b0) $display("FAIL single_one_shot: en=%b want 0", led_wr_enable); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic [31:0] r, a9, d9;
    bit acked;
    logic [4:0] x, y;
    int d;
    ready_mode = 0;
    repeat (3) @(posedge clk); #1;
    clear_queues();
    for (int i = 0; i < 9; i++) begin
      x = 5'($urandom_range(0, 31)); y = 5'($urandom_range(0, 31));
      d9 = {8'hA5, 24'($urandom)};
      a9 = pix_addr(x, y);
      exp_q.push_back({y, x, d9[23:0]});
      if (i < 8) wr(a9, d9);
    end
    bus_access(a9, d9, 4'h1, 20, 1'b1, r, acked);
    total_cnt++;
    if (acked !== 1'b0) $display("FAIL bp_ninth_stall: acked=%b want 0", acked); else pass_cnt++;
    rd(32'h1000_1000, r);
    total_cnt++;
    if (r !== 32'h0000_0208) $display("FAIL bp_status_full: got %h want %h", r, 32'h0000_0208); else pass_cnt++;
    ready_mode = 1;
    wr(a9, d9);
    wait_drain(9);
    d = first_diff();
    total_cnt++;
    if (d >= 0) $display("FAIL bp_sequence: diff at %0d got %0d strobes want %0d", d, obs_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_fill();
    logic [31:0] r;
    int d;
    ready_mode = 1;
    repeat (2) @(posedge clk); #1;
    clear_queues();
    wr(32'h1000_1004, rect_word(2, 3, 4, 4));
    wr(32'h1000_1008, 32'h0012_3456);
    rd(32'h1000_1000, r);
    model_fill(2, 3, 4, 4, 24'h123456);
    total_cnt++;
    if (r[8] !== 1'b1) $display("FAIL fill_busy_during: got %b want 1", r[8]); else pass_cnt++;
    wait_drain(6);
    d = first_diff();
    total_cnt++;
    if (d >= 0) $display("FAIL fill_sequence: diff at %0d got %0d strobes want %0d", d, obs_q.size(), exp_q.size());
    else pass_cnt++;
    rd(32'h1000_1000, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL fill_status_after: got %h want %h", r, 32'h0); else pass_cnt++;
  endtask

  task automatic test_fill_then_pixel();
    int x0, y0, x1, y1, d;
    logic [4:0] px, py;
    logic [23:0] c, pc;
    for (int it = 0; it < 3; it++) begin
      ready_mode = 2;
      clear_queues();
      x0 = $urandom_range(0, 26); x1 = x0 + $urandom_range(1, 5);
      y0 = $urandom_range(0, 28); y1 = y0 + $urandom_range(0, 3);
      c = 24'($urandom); pc = 24'($urandom);
      px = 5'($urandom_range(0, 31)); py = 5'($urandom_range(0, 31));
      wr(32'h1000_1004, rect_word(x0, y0, x1, y1));
      wr(32'h1000_1008, {8'h0, c});
      wr(pix_addr(px, py), {8'h0, pc});
      model_fill(x0, y0, x1, y1, c);
      exp_q.push_back({py, px, pc});
      ready_mode = 1;
      wait_drain(exp_q.size());
      d = first_diff();
      total_cnt++;
      if (d >= 0) $display("FAIL fill_then_pixel[%0d]: diff at %0d got %0d strobes want %0d", it, d, obs_q.size(), exp_q.size());
      else pass_cnt++;
    end
  endtask

  task automatic test_empty_rect();
    logic [31:0] r;
    ready_mode = 1;
    clear_queues();
    wr(32'h1000_1004, rect_word(5, 0, 4, 0));
    wr(32'h1000_1008, 32'h00FF_FFFF);
    rd(32'h1000_1000, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL empty_rect_status: got %h want %h", r, 32'h0); else pass_cnt++;
    repeat (20) @(posedge clk); #1;
    total_cnt++;
    if (obs_q.size() !== 0) $display("FAIL empty_rect_strobes: got %0d want 0", obs_q.size()); else pass_cnt++;
  endtask

  task automatic test_random_traffic();
    logic [31:0] r, a, w;
    int kind, d, bad_reads = 0;
    ready_mode = 2;
    clear_queues();
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      w = $urandom;
      if (kind <= 1) begin
        a = {20'h10000, 10'($urandom), 2'b00};
        bus_access(a, w, 4'($urandom_range(1, 15)), 300, 1'b0, r, bad_reads[31]);
        exp_q.push_back({a[11:7], a[6:2], w[23:0]});
      end else if (kind == 2) begin
        a = {20'h10001, 10'($urandom_range(4, 1023)), 2'b00};
        wr(a, w);
      end else begin
        case ($urandom_range(0, 3))
          0: a = 32'h1000_1004;
          1: a = 32'h1000_1008;
          2: a = {20'h10000, 10'($urandom), 2'b00};
          default: a = {20'h10001, 10'($urandom_range(3, 1023)), 2'b00};
        endcase
        rd(a, r);
        total_cnt++;
        if (r !== 32'h0) $display("FAIL other_read addr=%h: got %h want %h", a, r, 32'h0); else pass_cnt++;
      end
    end
    ready_mode = 1;
    wait_drain(exp_q.size());
    d = first_diff();
    total_cnt++;
    if (d >= 0) $display("FAIL random_sequence: diff at %0d got %0d strobes want %0d", d, obs_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_midfill();
    logic [31:0] r;
    int d;
    ready_mode = 0;
    repeat (3) @(posedge clk); #1;
    clear_queues();
    wr(32'h1000_1004, rect_word(0, 0, 9, 0));
    wr(32'h1000_1008, 32'h00AB_CDEF);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    total_cnt++;
    if ({mem_ready, mem_rdata, led_wr_enable, led_wr_addr_x, led_wr_addr_y, led_wr_rgb_data} !== 68'h0)
      $display("FAIL midfill_reset_outputs: ready=%b rdata=%h en=%b x=%0d y=%0d rgb=%h want all 0",
               mem_ready, mem_rdata, led_wr_enable, led_wr_addr_x, led_wr_addr_y, led_wr_rgb_data);
    else pass_cnt++;
    repeat (2) @(posedge clk); #1;
    ready_mode = 1;
    resetn = 1'b1;
    obs_q.delete();
    repeat (20) @(posedge clk); #1;
    total_cnt++;
    if (obs_q.size() !== 0) $display("FAIL midfill_no_strobes: got %0d want 0", obs_q.size()); else pass_cnt++;
    rd(32'h1000_1000, r);
    total_cnt++;
    if (r !== 32'h0) $display("FAIL midfill_status: got %h want %h", r, 32'h0); else pass_cnt++;
    // Cleared RECT means a COLOR write now paints only (0,0).
    clear_queues();
    wr(32'h1000_1008, 32'h0000_0055);
    model_fill(0, 0, 0, 0, 24'h000055);
    wait_drain(1);
    d = first_diff();
    total_cnt++;
    if (d >= 0) $display("FAIL rect_cleared_by_reset: diff at %0d got %0d strobes want %0d", d, obs_q.size(), exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_fill();
    test_fill_then_pixel();
    test_empty_rect();
    test_random_traffic();
    test_reset_midfill();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
